// File: rtl/gin_mc_sender.sv
// gin_mc_sender: source-side driver for the GIN multicast bus.
// Queues tagged packets and holds each on the bus until every destination
// whose ID matches the tag is ready. Packets that match no destination are
// discarded and counted.
module gin_mc_sender #(
   parameter int unsigned DATA_BITWIDTH = 8,
   parameter int unsigned TAG_BITWIDTH  = 3,
   parameter int unsigned NUM_DEST      = 4,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic                             i_clk,
   input  logic                             i_rst_n,
   input  logic [NUM_DEST*TAG_BITWIDTH-1:0] i_cfg_ids,
   input  logic                             i_cfg_load,
   output logic                             o_cfg_ready,
   input  logic [DATA_BITWIDTH-1:0]         i_data,
   input  logic [TAG_BITWIDTH-1:0]          i_tag,
   input  logic                             i_valid,
   output logic                             o_ready,
   output logic [DATA_BITWIDTH-1:0]         o_data,
   output logic [TAG_BITWIDTH-1:0]          o_tag,
   output logic                             o_valid,
   input  logic [NUM_DEST-1:0]              i_dest_ready,
   output logic [7:0]                       o_drop_cnt
);

   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned ENTRY_W = DATA_BITWIDTH + TAG_BITWIDTH;
   localparam int unsigned IDS_W   = NUM_DEST * TAG_BITWIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DROP = 2'd2
   } state_e;

   state_e                     state_q, state_d;
   logic [IDS_W-1:0]           ids_q, ids_d;
   logic [ENTRY_W-1:0]         mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [7:0]                 drop_cnt_q, drop_cnt_d;

   logic                       full, empty, push, pop, fire, all_ready, cfg_we;
   logic [ENTRY_W-1:0]         head_entry;
   logic [TAG_BITWIDTH-1:0]    head_tag;
   logic [DATA_BITWIDTH-1:0]   head_data;
   logic [NUM_DEST-1:0]        head_mask, nxt_mask;
   logic [PTR_W-1:0]           rd_ptr_inc;
   logic                       nxt_avail;
   logic [TAG_BITWIDTH-1:0]    nxt_tag;

   // Destinations whose configured ID equals the given tag
   function automatic logic [NUM_DEST-1:0] match_mask(input logic [IDS_W-1:0]        ids,
                                                      input logic [TAG_BITWIDTH-1:0] tag);
      logic [NUM_DEST-1:0] m;
      m = '0;
      for (int unsigned d = 0; d < NUM_DEST; d++) begin
         m[d] = (ids[d*TAG_BITWIDTH +: TAG_BITWIDTH] == tag);
      end
      return m;
   endfunction

   assign full        = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign empty       = (cnt_q == '0);
   assign o_ready     = !full;
   assign o_cfg_ready = (state_q == IDLE) && empty;
   assign cfg_we      = i_cfg_load && o_cfg_ready;
   assign push        = i_valid && !full;

   assign head_entry  = mem_q[rd_ptr_q];
   assign head_tag    = head_entry[TAG_BITWIDTH-1:0];
   assign head_data   = head_entry[ENTRY_W-1:TAG_BITWIDTH];
   assign head_mask   = match_mask(ids_q, head_tag);
   assign all_ready   = &(~head_mask | i_dest_ready);
   assign fire        = (state_q == SEND) && all_ready;
   assign pop         = fire || (state_q == DROP);
   assign rd_ptr_inc  = rd_ptr_q + PTR_W'(1);

   assign o_valid     = (state_q == SEND);
   assign o_data      = o_valid ? head_data : '0;
   assign o_tag       = o_valid ? head_tag  : '0;
   assign o_drop_cnt  = drop_cnt_q;

   // Tag of the entry that becomes head after a pop (may be this cycle's push)
   always_comb begin
      nxt_avail = 1'b0;
      nxt_tag   = '0;
      if (cnt_q > CNT_W'(1)) begin
         nxt_avail = 1'b1;
         nxt_tag   = mem_q[rd_ptr_inc][TAG_BITWIDTH-1:0];
      end else if (push) begin
         nxt_avail = 1'b1;
         nxt_tag   = i_tag;
      end
   end

   assign nxt_mask = match_mask(ids_q, nxt_tag);

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               state_d = (head_mask != '0) ? SEND : DROP;
            end
         end
         SEND, DROP: begin
            if (pop) begin
               if (!nxt_avail) begin
                  state_d = IDLE;
               end else begin
                  state_d = (nxt_mask != '0) ? SEND : DROP;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Queue pointers, count, ID registers and drop counter next values
   always_comb begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(push);
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
      cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
      ids_d      = ids_q;
      drop_cnt_d = drop_cnt_q;
      if (cfg_we) begin
         ids_d      = i_cfg_ids;
         drop_cnt_d = '0;
      end else if ((state_q == DROP) && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   // State and control registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         ids_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         ids_q      <= ids_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Queue storage; contents are only read once written, so no reset
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {i_data, i_tag};
      end
   end

endmodule
